// File: rtl/frontend_tl_arbiter.sv
// frontend_tl_arbiter: round-robin TileLink-UH arbiter sharing one memory port between icache refill (m0) and PTW (m1)
module frontend_tl_arbiter #(
  parameter int MAX_SIZE = 6
) (
  input  logic        cpu_clock_i,
  input  logic        reset_ni,
  input  logic [2:0]  m0_a_opcode,
  input  logic [2:0]  m0_a_param,
  input  logic [3:0]  m0_a_size,
  input  logic [31:0] m0_a_address,
  input  logic [3:0]  m0_a_mask,
  input  logic [31:0] m0_a_data,
  input  logic        m0_a_corrupt,
  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  output logic [2:0]  m0_d_opcode,
  output logic [1:0]  m0_d_param,
  output logic [3:0]  m0_d_size,
  output logic        m0_d_denied,
  output logic [31:0] m0_d_data,
  output logic        m0_d_corrupt,
  output logic        m0_d_valid,
  input  logic        m0_d_ready,
  input  logic [2:0]  m1_a_opcode,
  input  logic [2:0]  m1_a_param,
  input  logic [3:0]  m1_a_size,
  input  logic [31:0] m1_a_address,
  input  logic [3:0]  m1_a_mask,
  input  logic [31:0] m1_a_data,
  input  logic        m1_a_corrupt,
  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  output logic [2:0]  m1_d_opcode,
  output logic [1:0]  m1_d_param,
  output logic [3:0]  m1_d_size,
  output logic        m1_d_denied,
  output logic [31:0] m1_d_data,
  output logic        m1_d_corrupt,
  output logic        m1_d_valid,
  input  logic        m1_d_ready,
  output logic [2:0]  bus_a_opcode,
  output logic [2:0]  bus_a_param,
  output logic [3:0]  bus_a_size,
  output logic [31:0] bus_a_address,
  output logic [3:0]  bus_a_mask,
  output logic [31:0] bus_a_data,
  output logic        bus_a_corrupt,
  output logic        bus_a_valid,
  input  logic        bus_a_ready,
  input  logic [2:0]  bus_d_opcode,
  input  logic [1:0]  bus_d_param,
  input  logic [3:0]  bus_d_size,
  input  logic        bus_d_denied,
  input  logic [31:0] bus_d_data,
  input  logic        bus_d_corrupt,
  input  logic        bus_d_valid,
  output logic        bus_d_ready
);
  localparam int CW = MAX_SIZE - 1;
  localparam logic [1:0] IDLE = 2'd0, A_SEND = 2'd1, D_WAIT = 2'd2;
  logic [1:0]    state;
  logic          owner, last_grant, pick;
  logic [CW-1:0] cnt, d_beats, a_total, d_total;
  logic          a_send, d_wait, to0, to1, a_hs, d_hs, a_last, d_last;
  logic [2:0]    s_opcode;
  logic [3:0]    s_size;
  logic          s_valid;
  // beats carried by a transfer of 2^s bytes on the 4-byte bus, s clamped to MAX_SIZE
  function automatic logic [CW-1:0] beats(input logic [3:0] s);
    logic [3:0] c;
    c = (s > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : s;
    return (c < 4'd3) ? CW'(1) : CW'(1) << (c - 4'd2);
  endfunction
  assign a_send   = state == A_SEND;
  assign d_wait   = state == D_WAIT;
  assign to0      = d_wait & ~owner;
  assign to1      = d_wait & owner;
  assign s_opcode = owner ? m1_a_opcode : m0_a_opcode;
  assign s_size   = owner ? m1_a_size : m0_a_size;
  assign s_valid  = owner ? m1_a_valid : m0_a_valid;
  assign bus_a_opcode  = a_send ? s_opcode : '0;
  assign bus_a_param   = a_send ? (owner ? m1_a_param : m0_a_param) : '0;
  assign bus_a_size    = a_send ? s_size : '0;
  assign bus_a_address = a_send ? (owner ? m1_a_address : m0_a_address) : '0;
  assign bus_a_mask    = a_send ? (owner ? m1_a_mask : m0_a_mask) : '0;
  assign bus_a_data    = a_send ? (owner ? m1_a_data : m0_a_data) : '0;
  assign bus_a_corrupt = a_send & (owner ? m1_a_corrupt : m0_a_corrupt);
  assign bus_a_valid   = a_send & s_valid;
  assign m0_a_ready    = a_send & ~owner & bus_a_ready;
  assign m1_a_ready    = a_send & owner & bus_a_ready;
  assign m0_d_opcode   = to0 ? bus_d_opcode : '0;
  assign m0_d_param    = to0 ? bus_d_param : '0;
  assign m0_d_size     = to0 ? bus_d_size : '0;
  assign m0_d_denied   = to0 & bus_d_denied;
  assign m0_d_data     = to0 ? bus_d_data : '0;
  assign m0_d_corrupt  = to0 & bus_d_corrupt;
  assign m0_d_valid    = to0 & bus_d_valid;
  assign m1_d_opcode   = to1 ? bus_d_opcode : '0;
  assign m1_d_param    = to1 ? bus_d_param : '0;
  assign m1_d_size     = to1 ? bus_d_size : '0;
  assign m1_d_denied   = to1 & bus_d_denied;
  assign m1_d_data     = to1 ? bus_d_data : '0;
  assign m1_d_corrupt  = to1 & bus_d_corrupt;
  assign m1_d_valid    = to1 & bus_d_valid;
  assign bus_d_ready   = d_wait & (owner ? m1_d_ready : m0_d_ready);
  assign a_total = (s_opcode == 3'd0 || s_opcode == 3'd1) ? beats(s_size) : CW'(1);
  assign d_total = (s_opcode == 3'd4) ? beats(s_size) : CW'(1);
  assign a_hs    = bus_a_valid & bus_a_ready;
  assign d_hs    = bus_d_valid & bus_d_ready;
  assign a_last  = cnt == a_total - CW'(1);
  assign d_last  = cnt == d_beats - CW'(1);
  assign pick    = (m0_a_valid & m1_a_valid) ? ~last_grant : m1_a_valid;
  always_ff @(posedge cpu_clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      d_beats    <= '0;
    end else begin
      if (state == IDLE && (m0_a_valid | m1_a_valid)) begin
        owner      <= pick;
        last_grant <= pick;
        state      <= A_SEND;
      end
      if (a_hs) begin
        if (cnt == '0) d_beats <= d_total;
        cnt <= a_last ? '0 : cnt + CW'(1);
        if (a_last) state <= D_WAIT;
      end
      if (d_hs) begin
        cnt <= d_last ? '0 : cnt + CW'(1);
        if (d_last) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_frontend_tl_arbiter.sv
// tb_frontend_tl_arbiter: randomized requester/bus agents checked cycle by cycle against a transaction-level model
module tb_frontend_tl_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0]  a_op [2];
  logic [2:0]  a_par [2];
  logic [3:0]  a_sz [2];
  logic [31:0] a_addr [2];
  logic [3:0]  a_msk [2];
  logic [31:0] a_dat [2];
  logic        a_cor [2];
  logic        a_v [2];
  logic        d_rdy [2];
  logic        m_a_ready [2];
  logic [2:0]  m_d_opcode [2];
  logic [1:0]  m_d_param [2];
  logic [3:0]  m_d_size [2];
  logic        m_d_denied [2];
  logic [31:0] m_d_data [2];
  logic        m_d_corrupt [2];
  logic        m_d_valid [2];
  logic [2:0]  bus_a_opcode, bus_a_param;
  logic [3:0]  bus_a_size, bus_a_mask;
  logic [31:0] bus_a_address, bus_a_data;
  logic        bus_a_corrupt, bus_a_valid, bus_a_ready;
  logic [2:0]  bus_d_opcode;
  logic [1:0]  bus_d_param;
  logic [3:0]  bus_d_size;
  logic        bus_d_denied, bus_d_corrupt, bus_d_valid, bus_d_ready;
  logic [31:0] bus_d_data;
  frontend_tl_arbiter #(.MAX_SIZE(6)) dut (
    .cpu_clock_i(clk), .reset_ni(rst_n),
    .m0_a_opcode(a_op[0]), .m0_a_param(a_par[0]), .m0_a_size(a_sz[0]), .m0_a_address(a_addr[0]),
    .m0_a_mask(a_msk[0]), .m0_a_data(a_dat[0]), .m0_a_corrupt(a_cor[0]), .m0_a_valid(a_v[0]),
    .m0_a_ready(m_a_ready[0]), .m0_d_opcode(m_d_opcode[0]), .m0_d_param(m_d_param[0]),
    .m0_d_size(m_d_size[0]), .m0_d_denied(m_d_denied[0]), .m0_d_data(m_d_data[0]),
    .m0_d_corrupt(m_d_corrupt[0]), .m0_d_valid(m_d_valid[0]), .m0_d_ready(d_rdy[0]),
    .m1_a_opcode(a_op[1]), .m1_a_param(a_par[1]), .m1_a_size(a_sz[1]), .m1_a_address(a_addr[1]),
    .m1_a_mask(a_msk[1]), .m1_a_data(a_dat[1]), .m1_a_corrupt(a_cor[1]), .m1_a_valid(a_v[1]),
    .m1_a_ready(m_a_ready[1]), .m1_d_opcode(m_d_opcode[1]), .m1_d_param(m_d_param[1]),
    .m1_d_size(m_d_size[1]), .m1_d_denied(m_d_denied[1]), .m1_d_data(m_d_data[1]),
    .m1_d_corrupt(m_d_corrupt[1]), .m1_d_valid(m_d_valid[1]), .m1_d_ready(d_rdy[1]),
    .bus_a_opcode(bus_a_opcode), .bus_a_param(bus_a_param), .bus_a_size(bus_a_size),
    .bus_a_address(bus_a_address), .bus_a_mask(bus_a_mask), .bus_a_data(bus_a_data),
    .bus_a_corrupt(bus_a_corrupt), .bus_a_valid(bus_a_valid), .bus_a_ready(bus_a_ready),
    .bus_d_opcode(bus_d_opcode), .bus_d_param(bus_d_param), .bus_d_size(bus_d_size),
    .bus_d_denied(bus_d_denied), .bus_d_data(bus_d_data), .bus_d_corrupt(bus_d_corrupt),
    .bus_d_valid(bus_d_valid), .bus_d_ready(bus_d_ready)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic [2:0] ops [8] = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd4, 3'd2, 3'd3, 3'd5};
  logic busy [2], a_hs_seen [2], d_hs_seen [2];
  int   a_left_r [2], d_left_r [2];
  logic bus_d_acc;
  logic m_busy, m_own, m_last;
  int   m_a_left, m_d_left, m_d_done;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int nbeats(input logic [3:0] s);
    int c;
    c = (s > 4'd6) ? 6 : int'(s);
    return (c <= 2) ? 1 : (1 << (c - 2));
  endfunction
  function automatic int abeats(input logic [2:0] op, input logic [3:0] s);
    return (op == 3'd0 || op == 3'd1) ? nbeats(s) : 1;
  endfunction
  function automatic int dbeats(input logic [2:0] op, input logic [3:0] s);
    return (op == 3'd4) ? nbeats(s) : 1;
  endfunction
  task automatic start_txn(input int n);
    a_op[n]   = ops[$urandom_range(0, 7)];
    a_par[n]  = 3'($urandom);
    a_sz[n]   = 4'($urandom_range(0, 8));
    a_addr[n] = $urandom;
    a_msk[n]  = 4'($urandom);
    a_dat[n]  = $urandom;
    a_cor[n]  = 1'($urandom);
    a_v[n]    = 1'b1;
    busy[n]   = 1'b1;
    a_left_r[n] = abeats(a_op[n], a_sz[n]);
    d_left_r[n] = dbeats(a_op[n], a_sz[n]);
  endtask
  task automatic clear_all();
    for (int n = 0; n < 2; n++) begin
      a_v[n] = 1'b0; busy[n] = 1'b0; a_hs_seen[n] = 1'b0; d_hs_seen[n] = 1'b0;
      a_left_r[n] = 0; d_left_r[n] = 0; d_rdy[n] = 1'b0;
    end
    bus_d_valid = 1'b0; bus_d_acc = 1'b0; bus_a_ready = 1'b0;
    m_busy = 1'b0; m_own = 1'b0; m_last = 1'b1; m_a_left = 0; m_d_left = 0; m_d_done = 0;
  endtask
  task automatic step(input logic [1:0] frc, input logic rnd);
    logic sending, waiting, ownv;
    int o;
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (a_hs_seen[n]) begin
        a_left_r[n]--;
        if (a_left_r[n] <= 0) a_v[n] = 1'b0;
        else a_dat[n] = $urandom;
      end
      if (d_hs_seen[n]) d_left_r[n]--;
      if (busy[n] && a_left_r[n] <= 0 && d_left_r[n] <= 0) busy[n] = 1'b0;
      if (!busy[n] && (frc[n] || (rnd && $urandom_range(0, 3) == 0))) start_txn(n);
      d_rdy[n] = $urandom_range(0, 3) != 0;
    end
    bus_a_ready = $urandom_range(0, 2) != 0;
    if (!bus_d_valid || bus_d_acc) begin
      bus_d_valid   = 1'($urandom_range(0, 1));
      bus_d_opcode  = 3'($urandom);
      bus_d_param   = 2'($urandom);
      bus_d_size    = 4'($urandom);
      bus_d_denied  = 1'($urandom);
      bus_d_data    = $urandom;
      bus_d_corrupt = 1'($urandom);
    end
    #3;
    o = int'(m_own);
    sending = m_busy && m_a_left > 0;
    waiting = m_busy && m_a_left == 0;
    ownv = a_v[o];
    chk("bus_a_valid", 128'(bus_a_valid), 128'(sending && ownv));
    if (sending)
      chk("bus_a_fields",
          128'({bus_a_opcode, bus_a_param, bus_a_size, bus_a_address, bus_a_mask, bus_a_data, bus_a_corrupt}),
          128'({a_op[o], a_par[o], a_sz[o], a_addr[o], a_msk[o], a_dat[o], a_cor[o]}));
    chk("bus_d_ready", 128'(bus_d_ready), 128'(waiting && d_rdy[o]));
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("m%0d_a_ready", n), 128'(m_a_ready[n]), 128'(sending && o == n && bus_a_ready));
      chk($sformatf("m%0d_d_valid", n), 128'(m_d_valid[n]), 128'(waiting && o == n && bus_d_valid));
    end
    if (waiting && bus_d_valid)
      chk("d_fields",
          128'({m_d_opcode[o], m_d_param[o], m_d_size[o], m_d_denied[o], m_d_data[o], m_d_corrupt[o]}),
          128'({bus_d_opcode, bus_d_param, bus_d_size, bus_d_denied, bus_d_data, bus_d_corrupt}));
    for (int n = 0; n < 2; n++) begin
      a_hs_seen[n] = a_v[n] && m_a_ready[n];
      d_hs_seen[n] = m_d_valid[n] && d_rdy[n];
    end
    bus_d_acc = bus_d_valid && bus_d_ready;
    if (!m_busy) begin
      if (a_v[0] || a_v[1]) begin
        m_own = (a_v[0] && a_v[1]) ? !m_last : a_v[1];
        m_last = m_own;
        m_busy = 1'b1;
        m_a_left = abeats(a_op[int'(m_own)], a_sz[int'(m_own)]);
        m_d_left = dbeats(a_op[int'(m_own)], a_sz[int'(m_own)]);
        m_d_done = 0;
      end
    end else if (m_a_left > 0) begin
      if (ownv && bus_a_ready) m_a_left--;
    end else if (bus_d_valid && d_rdy[o]) begin
      m_d_left--;
      m_d_done++;
      if (m_d_left == 0) m_busy = 1'b0;
    end
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_hs"}, 128'({bus_a_valid, bus_d_ready, m_a_ready[0], m_a_ready[1], m_d_valid[0], m_d_valid[1]}), 128'(0));
    chk({tag, "_data"}, 128'({bus_a_address, bus_a_data, m_d_data[0], m_d_data[1], m_d_denied[0], m_d_denied[1]}), 128'(0));
  endtask
  initial begin
    logic hit;
    clear_all();
    for (int n = 0; n < 2; n++) begin
      start_txn(n);
      d_rdy[n] = 1'b1;
    end
    bus_a_ready = 1'b1;
    bus_d_valid = 1'b1; bus_d_data = 32'hCAFE_F00D; bus_d_denied = 1'b1;
    bus_d_opcode = 3'd1; bus_d_param = 2'd0; bus_d_size = 4'd2; bus_d_corrupt = 1'b0;
    #12;
    chk_quiet("reset");
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b11, 1'b0);
    repeat (2500) step(2'b00, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      step(2'b00, 1'b1);
      hit = m_busy && m_a_left == 0 && m_d_done >= 1 && m_d_left > 0;
    end
    chk("mid_d_wait_reached", 128'(hit), 128'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b10, 1'b0);
    repeat (4) step(2'b00, 1'b0);
    repeat (1500) step(2'b00, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
